// File: rtl/tlc_sensor_conditioner.sv
// ---------------------------------------------------------------------------
// tlc_sensor_conditioner
//   Turns five raw, asynchronous vehicle-detector inputs into clean presence
//   levels for the traffic light controller. Each channel is handled on its
//   own: the input is synchronized, then debounced when it asserts, and short
//   gaps are bridged when it releases. A channel that stays occupied for too
//   long raises a sticky fault flag. The fault does not change the sensor
//   level, so that direction is still served.
//
// Ports
//   clk            system clock (one cycle = one second tick)
//   reset_n        asynchronous, active-low reset
//   raw[4:0]       raw detectors: [0]=e_str [1]=w_str [2]=e_left [3]=w_left [4]=ns
//   fault_clr      synchronous pulse that clears all fault bits and stuck counters
//   *_sensor       conditioned presence outputs, driven only from registers
//   fault[4:0]     sticky stuck-detector flags, in the same bit order as raw
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// tlc_sc_channel: the conditioner for a single detector channel.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   IDLE     | no vehicle; waiting for the synchronized input to go high
//   QUAL     | input is high; counting consecutive high cycles up to DEB
//   PRESENT  | vehicle confirmed; sensor output is high
//   HOLD     | input dropped; bridging up to HOLD low cycles, output stays high
//
// Ports
//   clk, reset_n   clock and asynchronous active-low reset
//   i_raw          raw asynchronous detector input
//   i_fault_clr    synchronous clear of the fault flag and the stuck counter
//   o_sensor       registered presence level (high in PRESENT and HOLD)
//   o_fault        sticky flag: channel occupied for STUCK cycles in a row
// ---------------------------------------------------------------------------
module tlc_sc_channel #(
    parameter int DEB   = 3,
    parameter int HOLD  = 4,
    parameter int STUCK = 200
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_raw,
    input  logic i_fault_clr,
    output logic o_sensor,
    output logic o_fault
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_QUAL    = 2'd1,
        ST_PRESENT = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    localparam logic [3:0] DEB_M1   = 4'(DEB - 1);
    localparam logic [3:0] HOLD_C   = 4'(HOLD);
    localparam logic [7:0] STUCK_C  = 8'(STUCK);
    localparam logic [7:0] STUCK_M1 = 8'(STUCK - 1);

    state_t     r_state;
    logic       r_sync1;
    logic       r_sync2;
    logic [3:0] r_cnt;
    logic [7:0] r_stuck_cnt;
    logic       r_sensor;
    logic       r_fault;

    logic w_occupied;
    logic w_leave;

    assign w_occupied = (r_state == ST_PRESENT) || (r_state == ST_HOLD);

    // High on the edge where an occupied channel falls back to IDLE. The stuck
    // counter is cleared on that edge instead of being advanced.
    assign w_leave = ((r_state == ST_PRESENT) && !r_sync2 && (HOLD == 0)) ||
                     ((r_state == ST_HOLD) && !r_sync2 && (r_cnt == HOLD_C));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_stuck_cnt <= 8'd0;
            r_sensor    <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;

            case (r_state)
                ST_IDLE: begin
                    if (r_sync2) begin
                        if (DEB == 1) begin
                            r_state  <= ST_PRESENT;
                            r_sensor <= 1'b1;
                            r_cnt    <= 4'd0;
                        end else begin
                            r_state <= ST_QUAL;
                            r_cnt   <= 4'd1;
                        end
                    end
                end
                ST_QUAL: begin
                    if (!r_sync2) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 4'd0;
                    end else if (r_cnt == DEB_M1) begin
                        r_state  <= ST_PRESENT;
                        r_sensor <= 1'b1;
                        r_cnt    <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_PRESENT: begin
                    if (!r_sync2) begin
                        if (HOLD == 0) begin
                            r_state  <= ST_IDLE;
                            r_sensor <= 1'b0;
                            r_cnt    <= 4'd0;
                        end else begin
                            r_state <= ST_HOLD;
                            r_cnt   <= 4'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (r_sync2) begin
                        r_state <= ST_PRESENT;
                        r_cnt   <= 4'd0;
                    end else if (r_cnt == HOLD_C) begin
                        r_state  <= ST_IDLE;
                        r_sensor <= 1'b0;
                        r_cnt    <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_sensor <= 1'b0;
                    r_cnt    <= 4'd0;
                end
            endcase

            // The clear wins over a fault that would set on the same edge.
            // Outside PRESENT/HOLD the counter is held at zero, so it always
            // starts from zero on entry to PRESENT.
            if (i_fault_clr) begin
                r_stuck_cnt <= 8'd0;
                r_fault     <= 1'b0;
            end else if (w_occupied) begin
                if (w_leave) begin
                    r_stuck_cnt <= 8'd0;
                end else if (r_stuck_cnt != STUCK_C) begin
                    r_stuck_cnt <= r_stuck_cnt + 8'd1;
                    if (r_stuck_cnt == STUCK_M1) begin
                        r_fault <= 1'b1;
                    end
                end
            end else begin
                r_stuck_cnt <= 8'd0;
            end
        end
    end

    assign o_sensor = r_sensor;
    assign o_fault  = r_fault;

endmodule

module tlc_sensor_conditioner #(
    parameter int DEB   = 3,
    parameter int HOLD  = 4,
    parameter int STUCK = 200
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] raw,
    input  logic       fault_clr,
    output logic       e_str_sensor,
    output logic       w_str_sensor,
    output logic       e_left_sensor,
    output logic       w_left_sensor,
    output logic       ns_sensor,
    output logic [4:0] fault
);

    logic [4:0] w_sensor;
    logic [4:0] w_fault;

    for (genvar g = 0; g < 5; g++) begin : g_ch
        tlc_sc_channel #(
            .DEB   (DEB),
            .HOLD  (HOLD),
            .STUCK (STUCK)
        ) u_ch (
            .clk         (clk),
            .reset_n     (reset_n),
            .i_raw       (raw[g]),
            .i_fault_clr (fault_clr),
            .o_sensor    (w_sensor[g]),
            .o_fault     (w_fault[g])
        );
    end

    assign e_str_sensor  = w_sensor[0];
    assign w_str_sensor  = w_sensor[1];
    assign e_left_sensor = w_sensor[2];
    assign w_left_sensor = w_sensor[3];
    assign ns_sensor     = w_sensor[4];
    assign fault         = w_fault;

endmodule

// File: doc/tlc_sensor_conditioner.md
Name: tlc_sensor_conditioner

Overview:
Front-end stage directly upstream of the 5-direction traffic light controller. It converts five raw, asynchronous vehicle-detector inputs into the clean sensor levels the controller consumes: e_str, w_str, e_left, w_left and ns. Each channel is synchronized, debounced on assertion and gap-bridged on release. A channel that stays occupied too long raises a sticky fault flag; that channel's sensor output stays asserted so its direction is still served.

Parameters:
DEB, 3, consecutive synchronized-high cycles required before a sensor output asserts (1..15).
HOLD, 4, synchronized-low cycles tolerated before a sensor output deasserts (0..15; 0 = no bridging).
STUCK, 200, continuous occupied cycles after which the channel fault sets (1..255).

Ports:
clk  in  1  system clock (1 cycle = 1 s tick, same clock as controller)
reset_n  in  1  asynchronous, active-low reset
raw  in  5  raw detectors; [0]=e_str [1]=w_str [2]=e_left [3]=w_left [4]=ns; asynchronous
fault_clr  in  1  synchronous pulse; clears all fault bits and stuck counters
e_str_sensor  out  1  conditioned east straight presence
w_str_sensor  out  1  conditioned west straight presence
e_left_sensor  out  1  conditioned east left presence
w_left_sensor  out  1  conditioned west left presence
ns_sensor  out  1  conditioned north-south presence
fault  out  5  sticky stuck-detector flags, same bit order as raw

Behaviour:
- One clock domain. Reset is asynchronous, active-low, and stated exactly as: one clock; reset is asynchronous and active-low (reset_n).
- Reset (any time, including mid-debounce): sync flops=0, all channels IDLE, all counters=0, all sensor outputs=0, fault=0.
- Per channel: 2-flop synchronizer producing s, then an FSM with a 4-bit cnt and an 8-bit stuck_cnt. Channels are fully independent.
- The sensor output is driven from the state register: it is 1 in PRESENT and HOLD, otherwise 0. There is no combinational path from raw.
- IDLE: if s=1, go to QUAL with cnt=1; otherwise stay.
- QUAL: if s=0, go to IDLE with cnt=0. Else if cnt==DEB-1, go to PRESENT with stuck_cnt=0. Else cnt++.
- DEB=1: IDLE with s=1 goes directly to PRESENT.
- PRESENT: if s=0 and HOLD=0, go to IDLE. If s=0 and HOLD>0, go to HOLD with cnt=1. If s=1, stay.
- HOLD: if s=1, return to PRESENT; cnt is cleared and stuck_cnt is not cleared. If s=0 and cnt==HOLD, go to IDLE. Else cnt++.
- stuck_cnt increments on every edge in PRESENT or HOLD and saturates at STUCK. It clears on entry to IDLE.
- fault[i] sets on the edge where stuck_cnt reaches STUCK and is sticky. It has no effect on the sensor output.
- fault_clr=1: all fault bits and stuck_cnts go to 0 on that edge. This overrides a same-edge fault set. FSM states are unaffected; counting resumes next edge.
- Latency, raw first sampled high at edge 0 and held: output 1 after edge DEB+1.
- Latency, raw first sampled low at edge m and held: output 0 after edge m+2+HOLD.
- Simultaneous activity on several channels: no interaction; all five may be asserted together.

Test Plan:
1. Reset/debounce: reset_n=0 for 2 cycles, release; raw[4]=1 sampled from edge 0 -> ns_sensor=0 through edge 3, =1 after edge 4; all other outputs 0; fault=0.
2. Glitch reject: raw[0] high for exactly 2 sampled cycles (< DEB=3) -> e_str_sensor never asserts; channel returns to IDLE.
3. Gap bridging: raw[2] asserted long enough for e_left_sensor=1, then low for 3 cycles, then high -> e_left_sensor stays 1 throughout. Then low held from edge m -> output drops after edge m+6.
4. Stuck fault: raw[1] held high continuously -> w_str_sensor=1 after edge 4; fault[1]=1 after edge 204; output stays 1. fault_clr pulse at edge 210 -> fault=0 after 210, re-sets after edge 410.
5. Clear/set collision: fault_clr asserted on the same edge stuck_cnt reaches STUCK -> fault stays 0, stuck_cnt=0.
6. Async reset mid-operation: reset_n low between edges while three channels are in PRESENT/HOLD/QUAL -> all outputs and fault go to 0 immediately, without waiting for a clock edge. After release with raw still high, outputs reassert DEB+1 edges later.
